// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) / state-transform helpers.
// Used by both the encrypt and inverse cores.
package aes_pkg;

  localparam int unsigned RND_SIZE = 128;
  localparam int unsigned WRD_SIZE = 32;
  localparam int unsigned NUM_BLK  = RND_SIZE / WRD_SIZE;
  localparam int unsigned NUM_RND  = 10;
  localparam int unsigned CNT_SIZE = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEXP,
    ST_INIT,
    ST_ROUND
  } aes_state_e;

  function automatic logic [7:0] rcon(input logic [CNT_SIZE-1:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (squaring chain); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Byte k sits at bits [127-8k -: 8]; byte k is row k%4 of column k/4.
  function automatic logic [RND_SIZE-1:0] inv_shift_rows(input logic [RND_SIZE-1:0] s);
    logic [RND_SIZE-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned w = 0; w < 4; w++) begin
        r[RND_SIZE-1-8*(4*c+w) -: 8] = s[RND_SIZE-1-8*(4*((c+4-w)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [RND_SIZE-1:0] inv_mix_columns(input logic [RND_SIZE-1:0] s);
    logic [RND_SIZE-1:0] r;
    logic [31:0]         coefs;
    logic [7:0]          acc;
    r     = '0;
    coefs = 32'h0e0b0d09;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        acc = '0;
        for (int unsigned j = 0; j < 4; j++) begin
          acc = acc ^ gf_mul(coefs[31-8*((j+4-i)%4) -: 8], s[RND_SIZE-1-8*(4*c+j) -: 8]);
        end
        r[RND_SIZE-1-8*(4*c+i) -: 8] = acc;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box: inverse affine transform followed by the GF(2^8) inverse.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] b;

  always_comb begin
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    y = gf_inv(b);
  end

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] b;

  always_comb begin
    b = gf_inv(a);
    y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_inv_core_top.sv
// Iterative AES-128 inverse cipher, one round per clock. Expands the cipher key
// forward to rk10 in place, then walks the schedule backwards alongside the rounds.
module aes_inv_core_top
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [RND_SIZE-1:0] i_cypher,
  input  logic [RND_SIZE-1:0] i_key,
  output logic                o_valid,
  output logic [RND_SIZE-1:0] o_msg,
  output logic                o_ready,
  output logic                busy
);

  aes_state_e          state, state_nxt;
  logic [CNT_SIZE-1:0] cnt;
  logic [RND_SIZE-1:0] st, rk;

  logic [WRD_SIZE-1:0] w0, w1, w2, w3;
  logic [WRD_SIZE-1:0] sw_in, rot, sw_out, rcw;
  logic [RND_SIZE-1:0] rk_fwd, rk_inv;
  logic [RND_SIZE-1:0] sr, sb, ark, mixed;

  assign {w0, w1, w2, w3} = rk;

  // SubWord is shared: forward expansion feeds w3, the inverse step feeds w3^w2 (= new w3).
  always_comb begin
    sw_in  = (state == ST_KEXP) ? w3 : (w3 ^ w2);
    rot    = {sw_in[WRD_SIZE-9:0], sw_in[WRD_SIZE-1 -: 8]};
    rcw    = {rcon((state == ST_INIT) ? CNT_SIZE'(NUM_RND) : cnt), 24'h0};
    rk_fwd[RND_SIZE-1 -: WRD_SIZE] = w0 ^ sw_out ^ rcw;
    rk_fwd[95:64] = w1 ^ rk_fwd[127:96];
    rk_fwd[63:32] = w2 ^ rk_fwd[95:64];
    rk_fwd[31:0]  = w3 ^ rk_fwd[63:32];
    rk_inv = {w0 ^ sw_out ^ rcw, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  end

  for (genvar g = 0; g < NUM_BLK; g++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot[WRD_SIZE-1-8*g -: 8]),
      .y (sw_out[WRD_SIZE-1-8*g -: 8])
    );
  end

  assign sr = inv_shift_rows(st);

  for (genvar g = 0; g < RND_SIZE / 8; g++) begin : g_inv_sub
    aes_inv_sbox u_inv_sbox (
      .a (sr[RND_SIZE-1-8*g -: 8]),
      .y (sb[RND_SIZE-1-8*g -: 8])
    );
  end

  assign ark   = sb ^ rk;
  assign mixed = inv_mix_columns(ark);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_en) state_nxt = ST_KEXP;
      ST_KEXP:  if (cnt == CNT_SIZE'(NUM_RND)) state_nxt = ST_INIT;
      ST_INIT:  state_nxt = ST_ROUND;
      ST_ROUND: if (cnt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The ciphertext is parked in st at accept; INIT folds in rk10 in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      st      <= '0;
      rk      <= '0;
      o_msg   <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_en) begin
            st  <= i_cypher;
            rk  <= i_key;
            cnt <= CNT_SIZE'(1);
          end
        end
        ST_KEXP: begin
          rk  <= rk_fwd;
          cnt <= cnt + CNT_SIZE'(1);
        end
        ST_INIT: begin
          st  <= st ^ rk;
          rk  <= rk_inv;
          cnt <= CNT_SIZE'(NUM_RND - 1);
        end
        ST_ROUND: begin
          if (cnt == '0) begin
            o_msg   <= ark;
            o_valid <= 1'b1;
          end else begin
            st  <= mixed;
            rk  <= rk_inv;
            cnt <= cnt - CNT_SIZE'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state == ST_IDLE);
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_aes_inv_core_top.sv
// Directed and randomized bench for aes_inv_core_top; random cases are encrypted
// by a byte-level forward AES model and must decrypt back to the plaintext.
module tb_aes_inv_core_top;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_en;
  logic [127:0] i_cypher;
  logic [127:0] i_key;
  logic         o_valid;
  logic [127:0] o_msg;
  logic         o_ready;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sbox_t [256];

  aes_inv_core_top dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (i_en),
    .i_cypher (i_cypher),
    .i_key    (i_key),
    .o_valid  (o_valid),
    .o_msg    (o_msg),
    .o_ready  (o_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int unsigned x, y, r;
    x = a; y = b; r = 0;
    while (y != 0) begin
      if ((y & 1) != 0) r = r ^ x;
      x = x << 1;
      if ((x & 32'h100) != 0) x = x ^ 32'h11b;
      y = y >> 1;
    end
    return r[7:0];
  endfunction

  task automatic build_sbox();
    int unsigned inv, s;
    for (int unsigned v = 0; v < 256; v++) begin
      inv = 0;
      for (int unsigned y = 1; y < 256; y++)
        if (m_mul(8'(v), 8'(y)) == 8'h01) inv = y;
      s = inv;
      for (int unsigned k = 1; k <= 4; k++) s = s ^ (((inv << k) | (inv >> (8 - k))) & 32'hff);
      s = s ^ 32'h63;
      sbox_t[v] = s[7:0];
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] out;
    for (int unsigned i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int unsigned i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int unsigned k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int unsigned r = 1; r <= 10; r++) begin
      for (int unsigned k = 0; k < 16; k++) t[k] = sbox_t[s[k]];
      for (int unsigned c = 0; c < 4; c++)
        for (int unsigned row = 0; row < 4; row++)
          s[row+4*c] = t[row+4*((c+row)%4)];
      if (r < 10) begin
        for (int unsigned c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
          s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
        end
      end
      for (int unsigned k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
    end
    for (int unsigned k = 0; k < 16; k++) out[127-8*k -: 8] = s[k];
    return out;
  endfunction

  // One block: accept, wait for the pulse, check latency, handshake, result and hold.
  task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] exp, input bit probe_rk10, input logic [127:0] rk10_exp);
    int unsigned lat, bad;
    lat = 0; bad = 0;
    i_key = key; i_cypher = ct; i_en = 1'b1;
    step();
    i_en = 1'b0; i_key = ~key; i_cypher = ~ct;
    for (int unsigned i = 1; i <= 40 && lat == 0; i++) begin
      if (o_ready !== 1'b0 || busy !== 1'b1) bad++;
      step();
      if (probe_rk10 && i == 10) chk({tag, "_rk10"}, dut.rk, rk10_exp);
      if (o_valid === 1'b1) lat = i;
    end
    chk({tag, "_latency"}, 128'(lat), 128'd21);
    chk({tag, "_msg"}, o_msg, exp);
    chk({tag, "_busy_handshake"}, 128'(bad), 128'd0);
    chk({tag, "_ready_at_valid"}, 128'(o_ready), 128'd1);
    step();
    chk({tag, "_valid_pulse"}, 128'(o_valid), 128'd0);
    chk({tag, "_msg_hold"}, o_msg, exp);
  endtask

  initial begin
    int unsigned lat, bad;
    logic [127:0] k, p;

    rst_n = 1'b0; i_en = 1'b0; i_cypher = '0; i_key = '0;
    build_sbox();
    step();
    step();
    chk("rst_valid", 128'(o_valid), 128'd0);
    chk("rst_msg", o_msg, 128'd0);
    chk("rst_ready", 128'(o_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    step();

    run_block("fips_c1", K1, C1, P1, 1'b0, '0);
    run_block("fips_b", K2, C2, P2, 1'b1, RK10_2);

    // Back-to-back with i_en held high.
    i_key = K1; i_cypher = C1; i_en = 1'b1;
    step();
    i_key = K2; i_cypher = C2;
    lat = 0; bad = 0;
    for (int unsigned i = 1; i <= 40 && lat == 0; i++) begin
      if (o_ready !== 1'b0) bad++;
      step();
      if (o_valid === 1'b1) lat = i;
    end
    chk("b2b_lat_a", 128'(lat), 128'd21);
    chk("b2b_msg_a", o_msg, P1);
    chk("b2b_ready_a", 128'(o_ready), 128'd1);
    step();
    i_en = 1'b0;
    lat = 0;
    for (int unsigned i = 1; i <= 40 && lat == 0; i++) begin
      if (o_ready !== 1'b0) bad++;
      step();
      if (i == 10) chk("b2b_msg_hold", o_msg, P1);
      if (o_valid === 1'b1) lat = i;
    end
    chk("b2b_gap", 128'(lat), 128'd21);
    chk("b2b_msg_b", o_msg, P2);
    chk("b2b_ready_low", 128'(bad), 128'd0);
    step();

    // Request pulsed while busy must be ignored.
    i_key = K1; i_cypher = C1; i_en = 1'b1;
    step();
    i_en = 1'b0;
    lat = 0; bad = 0;
    for (int unsigned i = 1; i <= 40 && lat == 0; i++) begin
      if (o_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (i == 5) begin
        i_en = 1'b1; i_key = K2; i_cypher = C2;
      end else begin
        i_en = 1'b0;
      end
      step();
      if (o_valid === 1'b1) lat = i;
    end
    i_en = 1'b0;
    chk("ign_latency", 128'(lat), 128'd21);
    chk("ign_msg", o_msg, P1);
    chk("ign_handshake", 128'(bad), 128'd0);
    step();
    chk("ign_idle_after", 128'(busy), 128'd0);

    // Reset asserted at E12 aborts the block.
    i_key = K2; i_cypher = C2; i_en = 1'b1;
    step();
    i_en = 1'b0;
    for (int unsigned i = 1; i <= 11; i++) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 128'(o_valid), 128'd0);
    chk("mid_rst_msg", o_msg, 128'd0);
    chk("mid_rst_ready", 128'(o_ready), 128'd1);
    rst_n = 1'b1;
    bad = 0;
    for (int unsigned i = 0; i < 15; i++) begin
      step();
      if (o_valid !== 1'b0) bad++;
    end
    chk("mid_rst_no_pulse", 128'(bad), 128'd0);
    run_block("post_rst", K1, C1, P1, 1'b0, '0);

    // Round trip through the forward model.
    for (int unsigned n = 0; n < 100; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("rt%0d", n), k, ref_encrypt(k, p), p, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
